// File: rtl/vdp_layer_priority_mixer_pkg.sv
// vdp_layer_priority_mixer_pkg: layer encodings and reset-priority helper shared by the mixer.
package vdp_layer_priority_mixer_pkg;
  localparam logic [4:0] LAYER_BACKDROP = 5'b00000;
  localparam logic [4:0] LAYER_SCROLL0  = 5'b00001;
  localparam logic [4:0] LAYER_SCROLL1  = 5'b00010;
  localparam logic [4:0] LAYER_SCROLL2  = 5'b00100;
  localparam logic [4:0] LAYER_SCROLL3  = 5'b01000;
  localparam logic [4:0] LAYER_SPRITES  = 5'b10000;
  function automatic int layer_sprites_idx(input int n);
    return n;
  endfunction
  function automatic int reset_prio(input int i, input int prio_width);
    int p;
    p = (1 << prio_width) - 1 - i;
    return (p < 0) ? 0 : p;
  endfunction
endpackage

// File: rtl/vdp_priority_rank.sv
// vdp_priority_rank: combinational top-2 selection over {valid, score}; ties go to the lower index.
module vdp_priority_rank #(
  parameter int N = 5,
  parameter int W = 3
) (
  input  logic [N-1:0]   cand_valid,
  input  logic [N*W-1:0] scores,
  output logic [N-1:0]   top_sel,
  output logic [N-1:0]   under_sel,
  output logic [W-1:0]   top_score
);
  logic [W-1:0] under_score;
  always_comb begin
    top_sel = '0;
    under_sel = '0;
    top_score = '0;
    under_score = '0;
    for (int i = 0; i < N; i++)
      if (cand_valid[i] && (top_sel == '0 || scores[i*W +: W] > top_score)) begin
        top_sel = '0;
        top_sel[i] = 1'b1;
        top_score = scores[i*W +: W];
      end
    for (int i = 0; i < N; i++)
      if (cand_valid[i] && !top_sel[i] && (under_sel == '0 || scores[i*W +: W] > under_score)) begin
        under_sel = '0;
        under_sel[i] = 1'b1;
        under_score = scores[i*W +: W];
      end
  end
endmodule

// File: rtl/vdp_layer_priority_mixer.sv
// vdp_layer_priority_mixer: resolves scroll layers plus sprites into top and under opaque pixels,
// two-stage pipeline with double-buffered per-layer priorities committed at line start.
module vdp_layer_priority_mixer
  import vdp_layer_priority_mixer_pkg::*;
#(
  parameter int LAYER_COUNT = 4,
  parameter int PIXEL_WIDTH = 8,
  parameter int PRIO_WIDTH  = 2
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               cfg_write,
  input  logic [$clog2(LAYER_COUNT)-1:0]     cfg_layer,
  input  logic [PRIO_WIDTH-1:0]              cfg_priority,
  input  logic                               commit,
  input  logic                               in_valid,
  input  logic [LAYER_COUNT:0]               layer_mask,
  input  logic [LAYER_COUNT*PIXEL_WIDTH-1:0] scroll_pixels,
  input  logic [PRIO_WIDTH-1:0]              sprite_priority,
  input  logic [PIXEL_WIDTH-1:0]             sprite_pixel,
  output logic                               out_valid,
  output logic [LAYER_COUNT:0]               top_layer,
  output logic [PIXEL_WIDTH-1:0]             top_pixel,
  output logic [PRIO_WIDTH:0]                top_priority,
  output logic [LAYER_COUNT:0]               under_layer,
  output logic [PIXEL_WIDTH-1:0]             under_pixel
);
  localparam int N  = LAYER_COUNT + 1;
  localparam int SW = PRIO_WIDTH + 1;
  localparam int SI = layer_sprites_idx(LAYER_COUNT);
  logic [PRIO_WIDTH-1:0]    shadow_prio [LAYER_COUNT];
  logic [PRIO_WIDTH-1:0]    active_prio [LAYER_COUNT];
  logic [PRIO_WIDTH-1:0]    next_prio   [LAYER_COUNT];
  logic [N*SW-1:0]          scores, s1_scores;
  logic [N*PIXEL_WIDTH-1:0] s1_pixels;
  logic [N-1:0]             s1_mask, top_sel, under_sel;
  logic                     s1_valid;
  logic [SW-1:0]            top_score;
  logic [PIXEL_WIDTH-1:0]   top_mux, under_mux;
  // a write landing with commit passes straight through; out-of-range layers match nothing
  always_comb begin
    for (int i = 0; i < LAYER_COUNT; i++)
      next_prio[i] = (cfg_write && 32'(cfg_layer) == i) ? cfg_priority : shadow_prio[i];
  end
  always_comb begin
    scores = '0;
    for (int i = 0; i < LAYER_COUNT; i++)
      scores[i*SW +: SW] = {active_prio[i], 1'b0};
    scores[SI*SW +: SW] = {sprite_priority, 1'b1};
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)
      for (int i = 0; i < LAYER_COUNT; i++) begin
        shadow_prio[i] <= PRIO_WIDTH'(reset_prio(i, PRIO_WIDTH));
        active_prio[i] <= PRIO_WIDTH'(reset_prio(i, PRIO_WIDTH));
      end
    else begin
      shadow_prio <= next_prio;
      if (commit) active_prio <= next_prio;
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s1_mask   <= '0;
      s1_scores <= '0;
      s1_pixels <= '0;
    end else begin
      s1_valid  <= in_valid;
      s1_mask   <= layer_mask;
      s1_scores <= scores;
      s1_pixels <= {sprite_pixel, scroll_pixels};
    end
  vdp_priority_rank #(.N(N), .W(SW)) u_rank (
    .cand_valid(s1_mask),
    .scores    (s1_scores),
    .top_sel   (top_sel),
    .under_sel (under_sel),
    .top_score (top_score)
  );
  always_comb begin
    top_mux = '0;
    under_mux = '0;
    for (int i = 0; i < N; i++) begin
      top_mux   = top_mux   | (top_sel[i]   ? s1_pixels[i*PIXEL_WIDTH +: PIXEL_WIDTH] : '0);
      under_mux = under_mux | (under_sel[i] ? s1_pixels[i*PIXEL_WIDTH +: PIXEL_WIDTH] : '0);
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      out_valid    <= 1'b0;
      top_layer    <= '0;
      top_pixel    <= '0;
      top_priority <= '0;
      under_layer  <= '0;
      under_pixel  <= '0;
    end else begin
      out_valid    <= s1_valid;
      top_layer    <= top_sel;
      top_pixel    <= top_mux;
      top_priority <= top_score;
      under_layer  <= under_sel;
      under_pixel  <= under_mux;
    end
endmodule

// File: tb/tb_vdp_layer_priority_mixer.sv
// tb_vdp_layer_priority_mixer: directed vectors into a scoreboard queue, checked by a negedge monitor.
module tb_vdp_layer_priority_mixer;
  typedef struct packed {
    logic [4:0] tl;
    logic [7:0] tp;
    logic [2:0] tpr;
    logic [4:0] ul;
    logic [7:0] up;
  } exp_t;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_write = 1'b0;
  logic [1:0]  cfg_layer = '0;
  logic [1:0]  cfg_priority = '0;
  logic        commit = 1'b0;
  logic        in_valid = 1'b0;
  logic [4:0]  layer_mask = '0;
  logic [31:0] scroll_pixels = 32'h40302010;
  logic [1:0]  sprite_priority = '0;
  logic [7:0]  sprite_pixel = 8'h55;
  logic        out_valid;
  logic [4:0]  top_layer, under_layer;
  logic [7:0]  top_pixel, under_pixel;
  logic [2:0]  top_priority;
  exp_t        sb[$];
  exp_t        e;
  int          n_vec = 0;
  int          n_fail = 0;
  logic        done = 1'b0;
  vdp_layer_priority_mixer dut (
    .clk(clk), .reset_n(reset_n), .cfg_write(cfg_write), .cfg_layer(cfg_layer),
    .cfg_priority(cfg_priority), .commit(commit), .in_valid(in_valid), .layer_mask(layer_mask),
    .scroll_pixels(scroll_pixels), .sprite_priority(sprite_priority), .sprite_pixel(sprite_pixel),
    .out_valid(out_valid), .top_layer(top_layer), .top_pixel(top_pixel), .top_priority(top_priority),
    .under_layer(under_layer), .under_pixel(under_pixel)
  );
  always #5 clk = ~clk;
  task automatic drive(input logic v, input logic [4:0] m, input logic [1:0] sp, input exp_t x,
                       input logic cw = 1'b0, input logic [1:0] cl = 2'd0,
                       input logic [1:0] cp = 2'd0, input logic cm = 1'b0);
    @(negedge clk);
    in_valid = v;
    layer_mask = m;
    sprite_priority = sp;
    cfg_write = cw;
    cfg_layer = cl;
    cfg_priority = cp;
    commit = cm;
    if (v) sb.push_back(x);
  endtask
  always @(negedge clk) begin
    if (!reset_n) begin
      n_vec++;
      if ({out_valid, top_layer, top_pixel, top_priority, under_layer, under_pixel} !== '0) begin
        n_fail++;
        $display("FAIL reset_zero got v=%b tl=%b tp=%h tpr=%0d ul=%b up=%h, want all zero",
                 out_valid, top_layer, top_pixel, top_priority, under_layer, under_pixel);
      end
      sb.delete();
    end else if (out_valid) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output got tl=%b tp=%h, want no output", top_layer, top_pixel);
      end else begin
        e = sb.pop_front();
        if ({top_layer, top_pixel, top_priority, under_layer, under_pixel} !== e) begin
          n_fail++;
          $display("FAIL vector%0d got tl=%b tp=%h tpr=%0d ul=%b up=%h, want tl=%b tp=%h tpr=%0d ul=%b up=%h",
                   n_vec, top_layer, top_pixel, top_priority, under_layer, under_pixel,
                   e.tl, e.tp, e.tpr, e.ul, e.up);
        end
      end
    end
    if (done) begin
      if (sb.size() != 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL drain got %0d pending, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    drive(1, 5'b01111, 2'd0, '{5'b00001, 8'h10, 3'd6, 5'b00010, 8'h20});
    drive(1, 5'b11100, 2'd2, '{5'b10000, 8'h55, 3'd5, 5'b00100, 8'h30});
    drive(0, 5'b11111, 2'd0, '0);
    drive(1, 5'b00000, 2'd0, '0);
    drive(1, 5'b10000, 2'd0, '{5'b10000, 8'h55, 3'd1, 5'b00000, 8'h00});
    drive(1, 5'b01010, 2'd0, '{5'b00010, 8'h20, 3'd4, 5'b01000, 8'h40});
    drive(1, 5'b10001, 2'd3, '{5'b10000, 8'h55, 3'd7, 5'b00001, 8'h10});
    drive(1, 5'b10010, 2'd1, '{5'b00010, 8'h20, 3'd4, 5'b10000, 8'h55});
    drive(1, 5'b01100, 2'd0, '{5'b00100, 8'h30, 3'd2, 5'b01000, 8'h40}, 1'b1, 2'd3, 2'd3, 1'b0);
    drive(1, 5'b01100, 2'd0, '{5'b00100, 8'h30, 3'd2, 5'b01000, 8'h40});
    drive(1, 5'b01100, 2'd0, '{5'b00100, 8'h30, 3'd2, 5'b01000, 8'h40}, 1'b0, 2'd0, 2'd0, 1'b1);
    drive(1, 5'b01100, 2'd0, '{5'b01000, 8'h40, 3'd6, 5'b00100, 8'h30});
    drive(1, 5'b01001, 2'd0, '{5'b00001, 8'h10, 3'd6, 5'b01000, 8'h40});
    drive(1, 5'b00110, 2'd0, '{5'b00010, 8'h20, 3'd4, 5'b00100, 8'h30}, 1'b1, 2'd1, 2'd0, 1'b1);
    drive(1, 5'b00110, 2'd0, '{5'b00100, 8'h30, 3'd2, 5'b00010, 8'h20});
    drive(1, 5'b00110, 2'd0, '{5'b00100, 8'h30, 3'd2, 5'b00010, 8'h20}, 1'b1, 2'd2, 2'd0, 1'b0);
    drive(1, 5'b00110, 2'd0, '{5'b00100, 8'h30, 3'd2, 5'b00010, 8'h20}, 1'b1, 2'd2, 2'd2, 1'b0);
    drive(1, 5'b00110, 2'd0, '{5'b00100, 8'h30, 3'd2, 5'b00010, 8'h20}, 1'b0, 2'd0, 2'd0, 1'b1);
    drive(1, 5'b10100, 2'd1, '{5'b00100, 8'h30, 3'd4, 5'b10000, 8'h55});
    drive(1, 5'b01110, 2'd0, '{5'b01000, 8'h40, 3'd6, 5'b00100, 8'h30});
    drive(1, 5'b01110, 2'd0, '{5'b01000, 8'h40, 3'd6, 5'b00100, 8'h30});
    drive(1, 5'b01110, 2'd0, '{5'b01000, 8'h40, 3'd6, 5'b00100, 8'h30});
    @(posedge clk);
    #2 reset_n = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b1;
    drive(1, 5'b01110, 2'd0, '{5'b00010, 8'h20, 3'd4, 5'b00100, 8'h30});
    drive(1, 5'b01111, 2'd0, '{5'b00001, 8'h10, 3'd6, 5'b00010, 8'h20});
    drive(0, 5'b00000, 2'd0, '0);
    repeat (4) @(negedge clk);
    #1 done = 1'b1;
  end
endmodule
